// File: rtl/fft_out_reorder_pkg.sv
// Shared definitions for the FFT output reorder buffer.
//   DW_DEFAULT  : default width of one real/imaginary component
//   ST_FILL/REQ/ACK : state encoding of the drain state machine
//   bit_reverse : reverses the low 'width' bits of a value; drives the
//                 read address when FFT_BITREV_EN is defined
package fft_out_reorder_pkg;

    localparam int DW_DEFAULT = 16;

    localparam logic [1:0] ST_FILL = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_ACK  = 2'd2;

    // Bits at or above 'width' come back as zero.
    function automatic logic [31:0] bit_reverse(input logic [31:0] v, input int width);
        logic [31:0] r;
        r = '0;
        for (int b = 0; b < 32; b++) begin
            if (b < width) begin
                r[b] = v[width-1-b];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/fft_out_reorder_if.sv
// Bus between the FFT core, the reorder buffer and the serial output stage.
//   wr_en/wr_dR/wr_dJ/wr_ready : sample write port from the core
//   req_o/ans_i                : 4-phase handshake with the receiver
//   data_oR/data_oJ            : current output sample
//   frame_done/ovf             : status
// Modports: slave = reorder buffer, master = core plus receiver side.
interface fft_out_reorder_if
    import fft_out_reorder_pkg::*;
#(
    parameter int DW = DW_DEFAULT
) ();
    logic          wr_en;
    logic [DW-1:0] wr_dR;
    logic [DW-1:0] wr_dJ;
    logic          wr_ready;
    logic          req_o;
    logic          ans_i;
    logic [DW-1:0] data_oR;
    logic [DW-1:0] data_oJ;
    logic          frame_done;
    logic          ovf;

    modport slave (
        input  wr_en, wr_dR, wr_dJ, ans_i,
        output wr_ready, req_o, data_oR, data_oJ, frame_done, ovf
    );

    modport master (
        output wr_en, wr_dR, wr_dJ, ans_i,
        input  wr_ready, req_o, data_oR, data_oJ, frame_done, ovf
    );
endinterface

// File: rtl/fft_out_reorder_sync2.sv
// Two-flop synchronizer for a single asynchronous level.
//   clk : destination clock
//   rst : asynchronous active-high reset, output clears to 0
//   d   : asynchronous input
//   q   : synchronized output, two clk cycles of latency
module fft_out_reorder_sync2 (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);
    logic meta_reg;
    logic sync_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_reg <= 1'b0;
            sync_reg <= 1'b0;
        end else begin
            meta_reg <= d;
            sync_reg <= meta_reg;
        end
    end

    assign q = sync_reg;
endmodule

// File: rtl/fft_out_reorder.sv
// Frame buffer between the FFT core result port and the serial output stage.
// Collects 2^LOG2N complex samples in core order, then drains them one at a
// time over a 4-phase req/ans handshake paced by the receiver.
//   clk : system clock, rising edge
//   rst : asynchronous active-high reset, discards the buffered frame
//   bus : fft_out_reorder_if.slave (write port, handshake, status)
// Build option: define FFT_BITREV_EN to read in bit-reversed address order
// (natural frequency order out of a bit-reversed core); otherwise the frame
// leaves in write order.
module fft_out_reorder
    import fft_out_reorder_pkg::*;
#(
    parameter int LOG2N = 6,
    parameter int DW    = DW_DEFAULT
) (
    input  logic               clk,
    input  logic               rst,
    fft_out_reorder_if.slave   bus
);
    localparam int N = 1 << LOG2N;
    localparam logic [LOG2N-1:0] CNT_LAST = LOG2N'(N - 1);
    localparam logic [LOG2N-1:0] CNT_ONE  = LOG2N'(1);

    logic [1:0]       state_reg;
    logic [LOG2N-1:0] wr_cnt_reg;
    logic [LOG2N-1:0] rd_cnt_reg;
    logic [LOG2N-1:0] rd_addr;
    logic             req_reg;
    logic             done_reg;
    logic             ovf_reg;
    logic [DW-1:0]    out_r_reg;
    logic [DW-1:0]    out_j_reg;
    logic             ans_s;
    logic             wr_fire;

    logic [2*DW-1:0]  mem [N];

    fft_out_reorder_sync2 u_ans_sync (
        .clk (clk),
        .rst (rst),
        .d   (bus.ans_i),
        .q   (ans_s)
    );

`ifdef FFT_BITREV_EN
    assign rd_addr = LOG2N'(bit_reverse(32'(rd_cnt_reg), LOG2N));
`else
    assign rd_addr = rd_cnt_reg;
`endif

    assign wr_fire = (state_reg == ST_FILL) && bus.wr_en;

    // Storage carries no reset so it can map onto block RAM; the output
    // registers below form the registered read port.
    always_ff @(posedge clk) begin
        if (wr_fire) begin
            mem[wr_cnt_reg] <= {bus.wr_dR, bus.wr_dJ};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg  <= ST_FILL;
            wr_cnt_reg <= '0;
            rd_cnt_reg <= '0;
            req_reg    <= 1'b0;
            done_reg   <= 1'b0;
            ovf_reg    <= 1'b0;
            out_r_reg  <= '0;
            out_j_reg  <= '0;
        end else begin
            done_reg <= 1'b0;
            if (bus.wr_en && (state_reg != ST_FILL)) begin
                ovf_reg <= 1'b1;
            end
            case (state_reg)
                ST_FILL: begin
                    if (bus.wr_en) begin
                        wr_cnt_reg <= wr_cnt_reg + CNT_ONE;
                        if (wr_cnt_reg == CNT_LAST) begin
                            rd_cnt_reg <= '0;
                            state_reg  <= ST_REQ;
                        end
                    end
                end
                ST_REQ: begin
                    // req_reg low means this REQ visit has not loaded yet:
                    // load first, so req rises for at least one cycle even
                    // if ans_s is already high.
                    if (!req_reg) begin
                        {out_r_reg, out_j_reg} <= mem[rd_addr];
                        req_reg <= 1'b1;
                    end else if (ans_s) begin
                        req_reg   <= 1'b0;
                        state_reg <= ST_ACK;
                    end
                end
                ST_ACK: begin
                    if (!ans_s) begin
                        if (rd_cnt_reg == CNT_LAST) begin
                            done_reg   <= 1'b1;
                            rd_cnt_reg <= '0;
                            state_reg  <= ST_FILL;
                        end else begin
                            rd_cnt_reg <= rd_cnt_reg + CNT_ONE;
                            state_reg  <= ST_REQ;
                        end
                    end
                end
                default: begin
                    state_reg <= ST_FILL;
                    req_reg   <= 1'b0;
                end
            endcase
        end
    end

    assign bus.wr_ready   = (state_reg == ST_FILL);
    assign bus.req_o      = req_reg;
    assign bus.data_oR    = out_r_reg;
    assign bus.data_oJ    = out_j_reg;
    assign bus.frame_done = done_reg;
    assign bus.ovf        = ovf_reg;
endmodule

// File: tb/tb_fft_out_reorder.sv
// Directed testbench for fft_out_reorder with LOG2N=3, DW=16.
// Expected read order follows the FFT_BITREV_EN build option.
module tb_fft_out_reorder;
    import fft_out_reorder_pkg::*;

    logic clk;
    logic rst;
    int   checks   = 0;
    int   failures = 0;
    int   fd_cnt   = 0;

    fft_out_reorder_if #(.DW(16)) bus ();

    fft_out_reorder #(.LOG2N(3), .DW(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Counts cycles with frame_done high; a pulse of one cycle adds exactly 1.
    always @(negedge clk) begin
        if (bus.frame_done === 1'b1) fd_cnt++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int exp_addr(input int i);
        int r;
`ifdef FFT_BITREV_EN
        r = {i[0], i[1], i[2]};
`else
        r = i;
`endif
        return r;
    endfunction

    task automatic write_frame(input int base);
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            chk("wr_ready_fill", 32'(bus.wr_ready), 1);
            bus.wr_en = 1'b1;
            bus.wr_dR = 16'(base + k);
            bus.wr_dJ = 16'(32'h100 + base + k);
        end
        @(negedge clk);
        bus.wr_en = 1'b0;
        $display("wrote frame base=%0h", base);
    endtask

    // Waits for req, checks the sample, optionally holds ans low or injects
    // an overflow write, then raises ans and measures how long req takes to
    // fall. Leaves ans_i low again on return unless keep_ack is set.
    task automatic drain_sample(input int i, input int base, input bit hold,
                                input bit do_ovf, input bit keep_ack);
        int n;
        int e;
        n = 0;
        while (bus.req_o !== 1'b1 && n < 30) begin
            @(negedge clk);
            n++;
        end
        chk("req_rise", 32'(bus.req_o), 1);
        if (i > 0) chk("req_gap_ge3", 32'(n >= 3), 1);
        e = base + exp_addr(i);
        chk("data_r", 32'(bus.data_oR), e);
        chk("data_j", 32'(bus.data_oJ), 32'h100 + e);
        chk("wr_ready_drain", 32'(bus.wr_ready), 0);
        if (do_ovf) begin
            bus.wr_en = 1'b1;
            bus.wr_dR = 16'hDEAD;
            bus.wr_dJ = 16'hBEEF;
            @(negedge clk);
            bus.wr_en = 1'b0;
            chk("ovf_set", 32'(bus.ovf), 1);
            chk("ovf_data_r", 32'(bus.data_oR), e);
        end
        if (hold) begin
            for (int c = 0; c < 20; c++) begin
                @(negedge clk);
                chk("hold_stable", {bus.req_o, bus.wr_ready, bus.data_oR, bus.data_oJ[13:0]},
                    {1'b1, 1'b0, 16'(e), 14'(32'h100 + e)});
            end
        end
        bus.ans_i = 1'b1;
        n = 0;
        while (bus.req_o === 1'b1 && n < 10) begin
            @(negedge clk);
            n++;
        end
        chk("req_fall_lat", n, 3);
        if (!keep_ack) bus.ans_i = 1'b0;
        $display("sample %0d: R=%0h J=%0h", i, bus.data_oR, bus.data_oJ);
    endtask

    task automatic drain_frame(input int base, input int hold_idx, input int ovf_idx);
        int fd0;
        fd0 = fd_cnt;
        for (int i = 0; i < 8; i++) begin
            if (i == 7) chk("no_early_done", fd_cnt - fd0, 0);
            drain_sample(i, base, i == hold_idx, i == ovf_idx, 1'b0);
        end
        repeat (5) @(negedge clk);
        chk("frame_done_once", fd_cnt - fd0, 1);
        chk("back_to_fill", 32'(bus.wr_ready), 1);
        chk("req_idle", 32'(bus.req_o), 0);
        $display("frame base=%0h drained", base);
    endtask

    initial begin
        rst       = 1'b1;
        bus.wr_en = 1'b0;
        bus.wr_dR = '0;
        bus.wr_dJ = '0;
        bus.ans_i = 1'b0;
        #2;
        chk("rst_req", 32'(bus.req_o), 0);
        chk("rst_wr_ready", 32'(bus.wr_ready), 1);
        chk("rst_data", {bus.data_oR, bus.data_oJ}, 0);
        chk("rst_done_ovf", {bus.frame_done, bus.ovf}, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Frame 1: normal drain, receiver stalls on sample 2.
        write_frame(0);
        drain_frame(0, 2, -1);
        chk("ovf_clear", 32'(bus.ovf), 0);

        // Frame 2: stray write during the first REQ sets sticky ovf.
        write_frame(32'h10);
        drain_frame(32'h10, -1, 0);
        chk("ovf_sticky", 32'(bus.ovf), 1);

        // Frame 3: reset while in ACK with rd_cnt=3.
        write_frame(32'h40);
        for (int i = 0; i < 3; i++) drain_sample(i, 32'h40, 1'b0, 1'b0, 1'b0);
        drain_sample(3, 32'h40, 1'b0, 1'b0, 1'b1);
        rst = 1'b1;
        #1;
        chk("arst_req", 32'(bus.req_o), 0);
        chk("arst_data", {bus.data_oR, bus.data_oJ}, 0);
        chk("arst_wr_ready", 32'(bus.wr_ready), 1);
        chk("arst_ovf", 32'(bus.ovf), 0);
        bus.ans_i = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Frame 4: fresh frame drains from index 0.
        write_frame(32'h60);
        drain_frame(32'h60, -1, -1);
        chk("ovf_after_rst", 32'(bus.ovf), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
